// File: rtl/ram_b_core.sv
// ram_b_core: word-wide data RAM behind a multi-cycle request/ack handshake.
// A request is latched while idle, held for LATENCY cycles, then the access
// is performed and ack pulses for one cycle.
module ram_b_core #(
   parameter int unsigned ADDR_BITS = 10,
   parameter int unsigned LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        stall,
   output logic        ack
);

   localparam int unsigned DEPTH  = 1 << ADDR_BITS;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 we_q, we_d;
   logic [ADDR_BITS-1:0] idx_q, idx_d;
   logic [DATA_W-1:0]    din_q, din_d;
   logic [DATA_W-1:0]    dout_q, dout_d;
   logic                 ack_q, ack_d;
   logic                 mem_wr_c;

   // Backing array; contents start at zero and survive rst.
   logic [DATA_W-1:0]    mem [DEPTH] = '{default: '0};

   // Byte offset and high address bits are don't-care (aliasing/misalignment).
   logic unused_addr;
   assign unused_addr = ^{addr[31:ADDR_BITS+2], addr[1:0]};

   // State and datapath registers; rst aborts any pending access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         din_q   <= '0;
         dout_q  <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         din_q   <= din_d;
         dout_q  <= dout_d;
         ack_q   <= ack_d;
      end
   end

   // Next-state and access control.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      idx_d    = idx_q;
      din_d    = din_q;
      dout_d   = dout_q;
      ack_d    = 1'b0;
      mem_wr_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cs) begin
               we_d    = we;
               idx_d   = addr[ADDR_BITS+1:2];
               din_d   = din;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               ack_d   = 1'b1;
               state_d = DONE;
               if (we_q) begin
                  mem_wr_c = 1'b1;
               end else begin
                  dout_d = mem[idx_q];
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Array write port; suppressed while rst is asserted.
   always_ff @(posedge clk) begin
      if (!rst && mem_wr_c) begin
         mem[idx_q] <= din_q;
      end
   end

   // Requester hold: pending accept or access in flight.
   assign stall = ((state_q == IDLE) && cs) || (state_q == BUSY);
   assign dout  = dout_q;
   assign ack   = ack_q;

endmodule

// File: tb/tb_ram_b_core.sv
// tb_ram_b_core: scoreboard bench for ram_b_core (default parameters).
module tb_ram_b_core;

   localparam int unsigned ADDR_BITS = 10;
   localparam int unsigned LATENCY   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cs  = 1'b0;
   logic        we  = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] din  = '0;
   logic [31:0] dout;
   logic        stall;
   logic        ack;

   typedef struct {
      bit          is_rd;
      logic [31:0] data;
   } exp_t;

   exp_t        sbq[$];
   exp_t        e_mon;
   logic [31:0] model [int];
   logic [31:0] shadow_dout = '0;
   int          n_tests = 0;
   int          n_fail  = 0;

   ram_b_core #(.ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) dut (
      .clk   (clk),
      .rst   (rst),
      .cs    (cs),
      .we    (we),
      .addr  (addr),
      .din   (din),
      .dout  (dout),
      .stall (stall),
      .ack   (ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mread(input int idx);
      return model.exists(idx) ? model[idx] : 32'h0;
   endfunction

   // Scoreboard: every ack must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (ack) begin
         if (sbq.size() == 0) begin
            check("sb_unexpected_ack", 32'd1, 32'd0);
         end else begin
            e_mon = sbq.pop_front();
            check(e_mon.is_rd ? "sb_read_dout" : "sb_write_dout", dout, e_mon.data);
         end
      end
   end

   // One request; called at a negedge, returns at a negedge.
   task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d, input bit perturb);
      int   idx;
      int   n;
      exp_t e;
      idx = int'(a[ADDR_BITS+1:2]);
      if (w) begin
         model[idx] = d;
         e.is_rd = 1'b0;
         e.data  = shadow_dout;
      end else begin
         e.is_rd = 1'b1;
         e.data  = mread(idx);
         shadow_dout = e.data;
      end
      sbq.push_back(e);
      cs = 1'b1; we = w; addr = a; din = d;
      #1 check("stall_accept", 32'(stall), 32'd1);
      @(posedge clk);
      #1 cs = 1'b0;
      if (perturb) begin
         addr = 32'h20; din = 32'h5555_5555; we = 1'b1;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!ack) check("stall_busy", 32'(stall), 32'd1);
      end while (!ack && n < 20);
      check("ack_latency", 32'(n), 32'(LATENCY + 1));
      check("stall_done", 32'(stall), 32'd0);
      @(negedge clk);
      check("ack_width", 32'(ack), 32'd0);
   endtask

   initial begin
      int acks;
      int last;
      exp_t e;

      // Reset then idle
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_dout", dout, 32'h0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      @(negedge clk);

      // Write then read
      req(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
      req(1'b0, 32'h10, 32'h0, 1'b0);

      // Input change during BUSY has no effect
      req(1'b0, 32'h10, 32'h0, 1'b1);
      req(1'b0, 32'h20, 32'h0, 1'b0);

      // Aliasing and misalignment
      req(1'b1, 32'h1004, 32'h1234_5678, 1'b0);
      req(1'b0, 32'h4, 32'h0, 1'b0);
      req(1'b0, 32'h7, 32'h0, 1'b0);

      // Reset mid-operation aborts the write
      cs = 1'b1; we = 1'b1; addr = 32'h40; din = 32'hCAFE_F00D;
      @(posedge clk);
      #1 cs = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      shadow_dout = 32'h0;
      check("midrst_ack", 32'(ack), 32'd0);
      check("midrst_stall", 32'(stall), 32'd0);
      check("midrst_dout", dout, 32'h0);
      repeat (4) @(negedge clk);
      req(1'b0, 32'h40, 32'h0, 1'b0);
      req(1'b0, 32'h10, 32'h0, 1'b0);

      // Held cs: one ack every LATENCY+2 cycles
      for (int i = 0; i < 3; i++) begin
         e.is_rd = 1'b1;
         e.data  = mread(int'(32'h10 >> 2));
         sbq.push_back(e);
      end
      shadow_dout = mread(int'(32'h10 >> 2));
      cs = 1'b1; we = 1'b0; addr = 32'h10; din = 32'h0;
      acks = 0;
      last = 0;
      for (int n = 1; n <= 60 && acks < 3; n++) begin
         @(negedge clk);
         if (ack) begin
            check("held_stall_done", 32'(stall), 32'd0);
            if (acks == 0) check("held_first_ack", 32'(n), 32'(LATENCY + 1));
            else           check("held_period", 32'(n - last), 32'(LATENCY + 2));
            last = n;
            acks++;
            if (acks == 3) cs = 1'b0;
         end
      end
      check("held_ack_count", 32'(acks), 32'd3);
      repeat (6) @(negedge clk);
      check("sb_empty", 32'(sbq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global bound on run time.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ram_b_core.md
Name: ram_b_core

Overview:
- Word-wide data RAM with a multi-cycle request/acknowledge handshake, used as the backing store of the memory functional unit.
- The requester presents a byte address, write enable and write data with chip-select; the block stalls the requester for a fixed latency, performs the access, then pulses ack.
- The address arrives pre-computed (base + immediate, 32-bit modulo-2^32 sum, carry discarded); no address arithmetic is done inside this block.

Parameters:
- ADDR_BITS, 10, word-address width; depth = 2^ADDR_BITS 32-bit words (default 4 KiB).
- LATENCY, 2, cycles from request acceptance to access completion; legal range is 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- cs  input  1  chip-select / request valid; level-sampled only while idle.
- we  input  1  1 = write, 0 = read; sampled with cs.
- addr  input  32  byte address; word index = addr[ADDR_BITS+1:2]; bits [1:0] and bits above ADDR_BITS+1 are ignored.
- din  input  32  write data; sampled with cs.
- dout  output  32  read data; registered.
- stall  output  1  requester must hold/wait while high.
- ack  output  1  one-cycle completion pulse.

Behaviour:
- Memory array: 2^ADDR_BITS x 32 bits, all words initialised to 0 at time zero. rst does not clear the array.
- Reset (rst=1 at a rising edge): state=IDLE, counter=0, dout=0, ack=0, latched request cleared, no write performed. This takes priority over everything, including mid-operation (the pending access is aborted and nothing is written).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If cs=1 at an edge: latch we, word index and din; counter <= LATENCY-1; go to BUSY.
  - If cs=0: stay in IDLE.
- BUSY:
  - If counter != 0: decrement.
  - If counter == 0 at an edge: perform the access, ack <= 1, go to DONE.
  - Write access: mem[idx] <= latched din; dout unchanged.
  - Read access: dout <= mem[idx].
- DONE: ack <= 0; go to IDLE. cs is ignored in DONE; a new request is accepted on the following IDLE edge at the earliest.
- Timing: request accepted at edge k; access occurs at edge k+LATENCY; ack=1 for exactly the cycle after that edge; dout is valid in that cycle and holds until the next completed read or reset.
- stall (combinational) = (state==IDLE && cs) || state==BUSY. stall is 0 in DONE and in idle-without-request.
- Inputs are latched at acceptance; changes to addr, din or we during BUSY have no effect.
- Address wrap: word index is taken modulo depth. For example, with ADDR_BITS=10, 0x0000_1004 aliases 0x0000_0004.
- Read-after-write to the same word in back-to-back requests returns the newly written data.
- Misaligned byte addresses access the containing aligned word; there is no byte or halfword masking.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, cs=0 -> dout=0, ack=0, stall=0.
- Write then read: write addr=0x10, din=0xDEADBEEF (cs for 1 cycle, LATENCY=2) -> ack high exactly 3 cycles after acceptance edge's cycle start (cycle after edge k+2), stall high during accept and BUSY cycles. Read addr=0x10 -> dout=0xDEADBEEF with ack.
- Input change during BUSY: accept read of 0x10, then change addr to 0x20 and din during BUSY -> dout=0xDEADBEEF; mem[0x20] unchanged (reads 0).
- Aliasing and misalignment: write 0x12345678 to 0x1004 -> read 0x4 and 0x7 both return 0x12345678.
- Reset mid-operation: accept write 0xCAFEF00D to 0x40, assert rst during BUSY -> no ack, state IDLE, dout=0. Subsequent read of 0x40 -> 0x00000000; earlier word at 0x10 still 0xDEADBEEF.
- Held cs: keep cs=1 continuously with a read of 0x10 -> ack pulses once every LATENCY+2 cycles, one cycle wide each, stall=0 in each DONE cycle.
